sram_like_responder: RTL

SRAM_LIKE_RESPONDER -- requirements
Module: sram_like_responder

---
 rtl/sram_like_pkg.sv | 28 ++
 rtl/sram_resp_pipe.sv | 38 +++
 rtl/sram_like_responder.sv | 114 +++++++++++
 3 files changed

// File: rtl/sram_like_pkg.sv
// Shared constants and types for the SRAM-like responder.
// Holds the transfer-size encodings, the stall LFSR seed/taps and the
// response payload carried through the delay line.
package sram_like_pkg;

  // Transfer size encodings (informational; the responder always moves words)
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LFSR_W = 16;

  // Fibonacci LFSR, taps 16,14,13,11 -> state bits 15,13,12,10
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } resp_t;

  // One LFSR step: shift left, feedback is the XOR of the tapped bits
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sram_resp_pipe.sv
// Fixed-latency response delay line.
// Ports:
//   clk, reset : clock and synchronous active-high reset (clears every stage)
//   in_resp    : {valid, data} entering the line this cycle
//   valid      : response valid, DEPTH cycles after entry
//   data       : response data, DEPTH cycles after entry
module sram_resp_pipe
  import sram_like_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  resp_t             in_resp,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  resp_t stage [DEPTH];

  // Shift register; reset drops every in-flight response
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= in_resp;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign valid = stage[DEPTH-1].valid;
  assign data  = stage[DEPTH-1].data;

endmodule

// File: rtl/sram_like_responder.sv
// SRAM-like bus responder with fixed response latency and bounded
// outstanding requests, backed by a word-addressed memory.
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   req, wr      : request valid, 1 = write / 0 = read
//   size         : transfer size (informational only)
//   wstrb        : byte write enables
//   addr, wdata  : byte address and write data
//   addr_ok      : request accepted this cycle when high together with req
//   data_ok      : one-cycle response pulse per accepted request
//   rdata        : read data while data_ok is high, otherwise zero
module sram_like_responder
  import sram_like_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned LATENCY    = 3,
  parameter int unsigned MAX_OUT    = 2,
  parameter int unsigned RAND_STALL = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [3:0]        wstrb,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);
  localparam logic        ADDR_OK_RST = !((RAND_STALL != 0) && LFSR_SEED[0]);

  logic [DATA_W-1:0] mem [MEM_WORDS];

  logic [IDX_W-1:0]  idx_c;
  logic              hs_c;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  outstanding_nxt_c;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_nxt_c;
  logic              addr_ok_nxt_c;
  resp_t             pipe_in_c;
  logic              unused_c;

  assign idx_c = addr[IDX_W+1:2];
  assign hs_c  = req && addr_ok && !reset;

  // Size and the ignored address bits carry no function here
  assign unused_c = ^{size, addr[1:0], addr[31:IDX_W+2]};

  // Outstanding count: handshake adds one, response retires one
  always_comb begin
    outstanding_nxt_c = outstanding;
    if (hs_c && !data_ok) begin
      outstanding_nxt_c = outstanding + CNT_W'(1);
    end else if (!hs_c && data_ok) begin
      outstanding_nxt_c = outstanding - CNT_W'(1);
    end
  end

  // addr_ok is precomputed from next-cycle count and LFSR so it leaves a flop
  always_comb begin
    lfsr_nxt_c    = lfsr_next(lfsr);
    addr_ok_nxt_c = (outstanding_nxt_c < CNT_W'(MAX_OUT)) &&
                    !((RAND_STALL != 0) && lfsr_nxt_c[0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
      lfsr        <= LFSR_SEED;
      addr_ok     <= ADDR_OK_RST;
    end else begin
      outstanding <= outstanding_nxt_c;
      lfsr        <= lfsr_nxt_c;
      addr_ok     <= addr_ok_nxt_c;
    end
  end

  // Byte-masked write in the handshake cycle; memory is never reset
  always_ff @(posedge clk) begin
    if (hs_c && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) begin
          mem[idx_c][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Reads capture the word at handshake; write responses carry zero
  always_comb begin
    pipe_in_c       = '0;
    pipe_in_c.valid = hs_c;
    if (hs_c && !wr) begin
      pipe_in_c.data = mem[idx_c];
    end
  end

  sram_resp_pipe #(
    .DEPTH (LATENCY)
  ) u_pipe (
    .clk     (clk),
    .reset   (reset),
    .in_resp (pipe_in_c),
    .valid   (data_ok),
    .data    (rdata)
  );

endmodule
